// File: rtl/fifo_stream_drain.sv
// Drains words from fifo_sync onto a valid/ready stream and groups them into
// fixed-length packets, with a 3-entry queue absorbing the FIFO read latency.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]        LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [BW-1:0]        BEAT_ONE  = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [2:0][DATA_WIDTH-1:0] r_q;
    logic [2:0][DATA_WIDTH-1:0] w_q_nxt;
    logic [1:0]                 r_occ;
    logic [1:0]                 w_occ_nxt;
    logic [1:0]                 w_wr_idx;
    logic                       r_inflight;
    logic [BW-1:0]              r_beat;
    logic [CNT_WIDTH-1:0]       r_pkt_cnt;
    logic                       w_push;
    logic                       w_pop;

    // Credit uses only registered occupancy so m_ready never reaches fifo_rd_en.
    assign fifo_rd_en = !rst && enable && !fifo_empty &&
                        (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);

    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_q[0];
    assign m_last    = m_valid && (r_beat == LAST_BEAT);
    assign pkt_count = r_pkt_cnt;

    assign w_pop     = m_valid && m_ready;
    assign w_push    = r_inflight;
    assign w_wr_idx  = r_occ - {1'b0, w_pop};
    assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};

    // Head-aligned queue: pop shifts toward entry 0, push lands after the survivors.
    always_comb begin
        w_q_nxt = r_q;
        if (w_pop) begin
            w_q_nxt[0] = r_q[1];
            w_q_nxt[1] = r_q[2];
        end
        if (w_push) begin
            w_q_nxt[w_wr_idx] = fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_q        <= w_q_nxt;
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                if (m_last) begin
                    r_beat    <= '0;
                    r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
                end else begin
                    r_beat    <= r_beat + BEAT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream consumer of fifo_sync.
- Pops words from the FIFO read port (rd_en/dout/empty) and presents them on a valid/ready stream.
- Groups words into fixed-length packets, marks the last beat of each packet, and counts completed packets.
- Internal 3-entry output queue absorbs the FIFO's one-cycle read latency, giving full throughput under a registered credit scheme.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- PKT_LEN, 4, beats per packet (legal range 1..256).
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  permits new FIFO reads when high.
- fifo_empty  input  1  empty flag from fifo_sync.
- fifo_dout  input  DATA_WIDTH  read data from fifo_sync.
- fifo_rd_en  output  1  read strobe to fifo_sync.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_last  output  1  high on final beat of each packet.
- pkt_count  output  CNT_WIDTH  completed-packet counter.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port rst.
- Reset values: m_valid=0, m_last=0, m_data=0, pkt_count=0, fifo_rd_en=0. Queue occupancy=0, in-flight flag=0, beat index=0.
- FIFO contract: fifo_dout is registered and is valid in the cycle after a cycle with fifo_rd_en=1 and fifo_empty=0.
- Read issue:
  - fifo_rd_en = !rst && enable && !fifo_empty && (occ + inflight < 3).
  - occ and inflight are registered values only; there is no combinational path from m_ready to fifo_rd_en.
  - fifo_rd_en is never asserted while fifo_empty=1.
- In-flight tracking: inflight <= fifo_rd_en. When inflight=1, fifo_dout is pushed into the queue tail that cycle.
- Queue: 3-entry FIFO-ordered register queue.
  - Head drives m_data; m_valid = (occ != 0).
  - Push and pop in the same cycle leaves occ unchanged.
  - Overflow is impossible by the credit rule; it is not checked.
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops without a transfer, except on rst.
- Latency: first fifo_rd_en at cycle t produces m_valid=1 at cycle t+2.
- Throughput: with data available and m_ready held high, one beat per cycle sustained.
- Packetisation:
  - Beat index increments on each transfer.
  - m_last = (beat index == PKT_LEN-1) while m_valid=1.
  - On a transfer with m_last=1: beat index <= 0 and pkt_count increments.
  - pkt_count wraps from 2^CNT_WIDTH-1 to 0.
  - PKT_LEN=1 makes m_last high on every valid beat.
- enable low: no new reads are issued. In-flight and queued words still drain normally; the beat index is not reset.
- Reset mid-operation:
  - Queue contents and any in-flight word are discarded.
  - A word arriving on fifo_dout in the cycle rst is high is dropped.
  - Packet position restarts at beat 0.
- Simultaneous events: push, pop and issue may all happen in one cycle; occ updates by push minus pop.

Test Plan:
- Basic order: FIFO loaded with 1,2,3,4,5, m_ready=1, PKT_LEN=4 -> m_data 1..5 on consecutive cycles; m_last only on 4; pkt_count=1 after; m_valid low after 5.
- Throughput: 8 words preloaded, m_ready=1 -> 8 back-to-back valid beats; first fifo_rd_en at t, m_valid first high at t+2; m_last on beats 4 and 8; pkt_count=2.
- Backpressure: 8 words preloaded, m_ready=0 for 10 cycles -> exactly 3 fifo_rd_en pulses; m_data holds 1 with m_valid=1. Then m_ready=1 -> words 1..8 in order, no loss or duplication.
- Enable gating: enable drops after the 2nd read pulse -> exactly 2 words output, no further fifo_rd_en. Re-raising enable -> output resumes with word 3, m_last on word 4.
- Reset mid-stream: rst pulsed for 1 cycle after 2 beats transferred, with 2 queued and 1 in flight -> all outputs 0 the cycle after; queued/in-flight words never appear; the next packet's m_last falls on its 4th beat; pkt_count=0.
- Counter wrap: CNT_WIDTH=2, PKT_LEN=1, 5 words -> pkt_count sequence 1,2,3,0,1.
